// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - MMIO register offsets relative to MMIO_BASE
//   - region_t decode result
//   - merge_be(): byte-lane merge used by every byte-writable register
package dmem_pkg;

  localparam logic [31:0] OFF_MTIME_LO    = 32'h0000_0000;
  localparam logic [31:0] OFF_MTIME_HI    = 32'h0000_0004;
  localparam logic [31:0] OFF_MTIMECMP_LO = 32'h0000_0008;
  localparam logic [31:0] OFF_MTIMECMP_HI = 32'h0000_000C;
  localparam logic [31:0] OFF_TOHOST      = 32'h0000_0010;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_t;

  // Lanes with be[i]=1 take new_w, the rest keep old_w.
  function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_timer.sv
// dmem_timer: machine timer for the data-memory responder.
//   Tick divider, 64-bit mtime / mtimecmp and the registered timer_irq compare.
// Ports:
//   clk, rst_n        core clock, asynchronous active-low reset
//   sel_mtime_lo/hi   byte write to mtime half this cycle (already decoded)
//   sel_cmp_lo/hi     byte write to mtimecmp half this cycle (already decoded)
//   we, wdata         byte-lane enables and lane-aligned store data
//   mtime, mtimecmp   current register values (for reads)
//   timer_irq         registered (mtime >= mtimecmp) of the post-update values
module dmem_timer
  import dmem_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel_mtime_lo,
  input  logic        sel_mtime_hi,
  input  logic        sel_cmp_lo,
  input  logic        sel_cmp_hi,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        timer_irq
);

  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

  logic [31:0] tick_cnt_p0;
  logic        tick_p0;
  logic [31:0] lo_inc_p0;
  logic [63:0] mtime_nxt_p0;
  logic [63:0] cmp_nxt_p0;

  assign tick_p0 = (tick_cnt_p0 == TICK_LAST);

  // A CPU write to either mtime half wins over the increment for its lanes;
  // on that cycle the low half still ticks but never carries into the high half.
  always_comb begin
    lo_inc_p0    = mtime[31:0] + {31'b0, tick_p0};
    mtime_nxt_p0 = mtime + {63'b0, tick_p0};
    cmp_nxt_p0   = mtimecmp;
    if (sel_mtime_lo) begin
      mtime_nxt_p0 = {mtime[63:32], merge_be(lo_inc_p0, wdata, we)};
    end else if (sel_mtime_hi) begin
      mtime_nxt_p0 = {merge_be(mtime[63:32], wdata, we), lo_inc_p0};
    end
    if (sel_cmp_lo) cmp_nxt_p0[31:0]  = merge_be(mtimecmp[31:0], wdata, we);
    if (sel_cmp_hi) cmp_nxt_p0[63:32] = merge_be(mtimecmp[63:32], wdata, we);
  end

  // ---- stage p0 -> registered timer state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_p0 <= '0;
      mtime       <= '0;
      mtimecmp    <= '1;
      timer_irq   <= 1'b0;
    end else begin
      tick_cnt_p0 <= tick_p0 ? '0 : tick_cnt_p0 + 32'd1;
      mtime       <= mtime_nxt_p0;
      mtimecmp    <= cmp_nxt_p0;
      timer_irq   <= (mtime_nxt_p0 >= cmp_nxt_p0);
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the single-cycle RV32 core.
//   Word-addressed RAM, MMIO machine timer and tohost halt register.
//   Every cycle is a request; rdata/err return exactly one clock later.
//   Stores are read-first: rdata of a store cycle is the pre-write word.
// Build option:
//   DMEM_TIMER_EN  defined   -> dmem_timer instantiated, timer_irq live
//                  undefined -> timer offsets read 0, writes dropped, timer_irq=0
// Ports:
//   clk, rst_n   core clock, asynchronous active-low reset
//   addr         byte address (addr[1:0] ignored)
//   we           byte-lane write enables, 0 = read
//   wdata        lane-aligned store data
//   rdata        word at the address of the previous cycle
//   timer_irq    registered mtime >= mtimecmp
//   halt         sticky, set by a nonzero write to tohost
//   exit_code    last nonzero tohost value
//   err          one-cycle pulse alongside rdata for an unmapped access
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        timer_irq,
  output logic        halt,
  output logic [31:0] exit_code,
  output logic        err
);

  localparam int RAM_WORDS = 1 << ADDR_W;

  logic [31:0] mem [RAM_WORDS];

  logic [31:0]       word_addr_p0;
  logic [31:0]       mmio_off_p0;
  logic [ADDR_W-1:0] ram_idx_p0;
  region_t           region_p0;
  logic              wr_any_p0;
  logic              ram_we_p0;
  logic              tohost_we_p0;
  logic [31:0]       tohost_merged_p0;
  logic [31:0]       rd_word_p0;
  logic              err_p0;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^addr[1:0];

  assign word_addr_p0 = {addr[31:2], 2'b00};
  assign mmio_off_p0  = word_addr_p0 - MMIO_BASE;
  assign ram_idx_p0   = addr[ADDR_W+1:2];
  assign wr_any_p0    = |we;

  always_comb begin
    region_p0 = REG_NONE;
    if (addr[31:ADDR_W+2] == '0)        region_p0 = REG_RAM;
    else if (mmio_off_p0 <= OFF_TOHOST) region_p0 = REG_MMIO;
  end

  assign ram_we_p0    = wr_any_p0 && (region_p0 == REG_RAM);
  assign tohost_we_p0 = wr_any_p0 && (region_p0 == REG_MMIO) && (mmio_off_p0 == OFF_TOHOST);
  // tohost reads back as exit_code, so the merge base is exit_code itself.
  assign tohost_merged_p0 = merge_be(exit_code, wdata, we);

`ifdef DMEM_TIMER_EN
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        mmio_wr_p0;

  assign mmio_wr_p0 = wr_any_p0 && (region_p0 == REG_MMIO);

  dmem_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .sel_mtime_lo (mmio_wr_p0 && (mmio_off_p0 == OFF_MTIME_LO)),
    .sel_mtime_hi (mmio_wr_p0 && (mmio_off_p0 == OFF_MTIME_HI)),
    .sel_cmp_lo   (mmio_wr_p0 && (mmio_off_p0 == OFF_MTIMECMP_LO)),
    .sel_cmp_hi   (mmio_wr_p0 && (mmio_off_p0 == OFF_MTIMECMP_HI)),
    .we           (we),
    .wdata        (wdata),
    .mtime        (mtime),
    .mtimecmp     (mtimecmp),
    .timer_irq    (timer_irq)
  );
`else
  assign timer_irq = 1'b0;
`endif

  // Read mux sees the pre-write state, which gives read-first stores.
  always_comb begin
    rd_word_p0 = '0;
    err_p0     = 1'b0;
    case (region_p0)
      REG_RAM:  rd_word_p0 = mem[ram_idx_p0];
      REG_MMIO: begin
        case (mmio_off_p0)
`ifdef DMEM_TIMER_EN
          OFF_MTIME_LO:    rd_word_p0 = mtime[31:0];
          OFF_MTIME_HI:    rd_word_p0 = mtime[63:32];
          OFF_MTIMECMP_LO: rd_word_p0 = mtimecmp[31:0];
          OFF_MTIMECMP_HI: rd_word_p0 = mtimecmp[63:32];
`endif
          OFF_TOHOST:      rd_word_p0 = exit_code;
          default:         rd_word_p0 = '0;
        endcase
      end
      default:  err_p0 = 1'b1;
    endcase
  end

  // RAM is not reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (ram_we_p0) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[ram_idx_p0][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // ---- stage p0 -> p1: response and tohost registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata     <= '0;
      err       <= 1'b0;
      halt      <= 1'b0;
      exit_code <= '0;
    end else begin
      rdata <= rd_word_p0;
      err   <= err_p0;
      if (tohost_we_p0 && (tohost_merged_p0 != '0)) begin
        halt      <= 1'b1;
        exit_code <= tohost_merged_p0;
      end
    end
  end

endmodule
